// File: rtl/regfile_fifo_pkg.sv
// Shared constants and types for the register-file FIFO controller.
// Pure definitions: no latency, no flow control.
package regfile_fifo_pkg;

    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 4;
    localparam int DEPTH        = 1 << ADDR_W;
    localparam int CNT_W        = ADDR_W + 1;
    localparam int AFULL_TH_DEF = 28;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Occupancy after one cycle; simultaneous push and pop cancel out.
    function automatic cnt_t next_count(input cnt_t cur, input logic push, input logic pop);
        cnt_t nxt;
        nxt = cur;
        if (push && !pop) begin
            nxt = cur + cnt_t'(1);
        end else if (pop && !push) begin
            nxt = cur - cnt_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/regfile_fifo_ctrl_if.sv
// Streaming and register-file bus bundle for the FIFO controller.
// slave = controller view; master = producer/consumer/register-file view.
interface regfile_fifo_ctrl_if;
    import regfile_fifo_pkg::*;

    logic  wr_valid;
    logic  wr_ready;
    data_t wr_data;
    logic  rd_valid;
    logic  rd_ready;
    data_t rd_data;
    data_t rf_D;
    addr_t rf_W_ADR;
    logic  rf_W_en;
    addr_t rf_A_ADR;
    data_t rf_AD;

    modport slave (
        input  wr_valid, wr_data, rd_ready, rf_AD,
        output wr_ready, rd_valid, rd_data, rf_D, rf_W_ADR, rf_W_en, rf_A_ADR
    );

    modport master (
        output wr_valid, wr_data, rd_ready, rf_AD,
        input  wr_ready, rd_valid, rd_data, rf_D, rf_W_ADR, rf_W_en, rf_A_ADR
    );

endinterface

// File: rtl/regfile_fifo_ptr.sv
// Wrapping ADDR_W-bit pointer; advances one cycle after inc, wraps 31->0 naturally.
// No flow control of its own: the caller gates inc with the handshake.
module regfile_fifo_ptr
    import regfile_fifo_pkg::*;
(
    input  logic  UserCLK,
    input  logic  RST,
    input  logic  inc,
    output addr_t ptr
);

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + addr_t'(1);
        end
    end

endmodule

// File: rtl/regfile_fifo_ctrl.sv
// First-word-fall-through FIFO controller over the 32x4 register file (port A combinational);
// write-to-read latency 1 cycle; wr_ready/rd_valid depend only on state and RST. Option: REGFILE_FIFO_LEVEL_EN.
module regfile_fifo_ctrl
    import regfile_fifo_pkg::*;
`ifdef REGFILE_FIFO_LEVEL_EN
#(
    parameter int AFULL_TH = AFULL_TH_DEF
)
`endif
(
    input  logic                  UserCLK,
    input  logic                  RST,
    regfile_fifo_ctrl_if.slave    bus
`ifdef REGFILE_FIFO_LEVEL_EN
    ,
    output cnt_t                  level,
    output logic                  almost_full
`endif
);

    addr_t wr_ptr;
    addr_t rd_ptr;
    cnt_t  count;
    cnt_t  count_nxt;
    logic  wr_fire;
    logic  rd_fire;

    // Flags come from registered state only, so a read on a full FIFO
    // cannot open a write slot in the same cycle.
    always_comb begin
        bus.wr_ready = !RST && (count != cnt_t'(DEPTH));
        bus.rd_valid = !RST && (count != '0);
    end

    assign wr_fire = bus.wr_valid && bus.wr_ready;
    assign rd_fire = bus.rd_valid && bus.rd_ready;

    assign bus.rf_W_en  = wr_fire;
    assign bus.rf_W_ADR = wr_ptr;
    assign bus.rf_D     = bus.wr_data;
    assign bus.rf_A_ADR = rd_ptr;
    assign bus.rd_data  = bus.rf_AD;

    regfile_fifo_ptr u_wr_ptr (
        .UserCLK (UserCLK),
        .RST     (RST),
        .inc     (wr_fire),
        .ptr     (wr_ptr)
    );

    regfile_fifo_ptr u_rd_ptr (
        .UserCLK (UserCLK),
        .RST     (RST),
        .inc     (rd_fire),
        .ptr     (rd_ptr)
    );

    always_comb begin
        count_nxt = next_count(count, wr_fire, rd_fire);
    end

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

`ifdef REGFILE_FIFO_LEVEL_EN
    assign level       = count;
    assign almost_full = (count >= cnt_t'(AFULL_TH));
`endif

endmodule
